lcm_from_gcd: RTL and testbench
===============================

Name: lcm_from_gcd

Overview:
- Downstream consumer of the Stein GCD block.
- Takes the same operand pair P, Q plus the GCD result R, and computes LCM = (P / R) * Q as a 2W-bit value.
- Clocked, multi-cycle datapath: shift-subtract divider, then shift-add multiplier.
- valid/ready handshake on both input and output, so it can sit between the GCD stage and a result sink.

Parameters:
- W, 8, operand width of p, q, gcd. Result width is 2*W. Divide and multiply each take W iterations.

Ports:
- clk  input  1  single clock, rising-edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand triple valid.
- in_ready  output  1  block can accept a triple.
- p  input  W  operand P as fed to the GCD stage.
- q  input  W  operand Q as fed to the GCD stage.
- gcd  input  W  GCD(P,Q) produced by the GCD stage.
- out_valid  output  1  result valid.
- out_ready  input  1  sink accepts result.
- lcm  output  2W  least common multiple.
- err  output  1  inconsistent input: gcd==0 with nonzero operands, or gcd does not divide p.

Behaviour:
- Reset (rst low, any time, asynchronous): state=IDLE, in_ready=1, out_valid=0, lcm=0, err=0; all internal registers cleared.
- Reset mid-operation aborts the computation; no result is produced.
- States:
  - IDLE: in_ready=1. On an edge with in_valid&&in_ready, latch p, q, gcd. Transition:
    - If p==0 or q==0: go to DONE with lcm=0, err=0 (fast path, out_valid after 1 edge).
    - Else if gcd==0: go to DONE with lcm=0, err=1.
    - Else: go to DIV, iteration counter=0.
  - DIV: restoring division of p by gcd, one quotient bit per edge, MSB first, W edges. After the W-th edge:
    - remainder!=0: go to DONE with lcm=0, err=1.
    - else: quotient kept, go to MUL.
  - MUL: shift-add of quotient * q, one multiplier bit per edge, LSB first, W edges, 2W-bit accumulator. After the W-th edge go to DONE with lcm=accumulator, err=0. No overflow is possible, since (2^W-1)^2 < 2^(2W).
  - DONE: out_valid=1. lcm/err stable while out_valid && !out_ready. On an edge with out_valid&&out_ready go to IDLE; out_valid drops that edge.
- in_ready=1 only in IDLE; the block never accepts a new triple while busy or holding a result.
- Latency, normal path: out_valid rises 2W+1 edges after the accept edge (17 for W=8). Fast path / gcd==0: 1 edge.
- Throughput: one result per 2W+2 cycles minimum with out_ready held high.
- Inputs p, q, gcd are sampled only on the accept edge; later changes are ignored.
- lcm and err hold their last value in IDLE (not cleared) until the next DONE.

Optional Feature:
- Macro: LCM_CHECK_Q_EN.
- Defined:
  - Extra state QCHK between DIV and MUL runs a second W-edge restoring division of q by gcd.
  - Nonzero remainder: go to DONE with lcm=0, err=1.
  - Normal-path latency becomes 3W+1 edges (25 for W=8).
- Undefined: no QCHK state, q divisibility is not checked, latency 2W+1.

Test Plan:
- Basic results (W=8, out_ready=1):
  - p=8, q=4, gcd=4 -> lcm=8, err=0, out_valid exactly 17 edges after accept.
  - p=100, q=25, gcd=25 -> lcm=100.
  - p=67, q=9, gcd=1 -> lcm=603.
- Fast paths:
  - p=0, q=3, gcd=3 -> lcm=0, err=0 after 1 edge.
  - p=3, q=3, gcd=0 -> lcm=0, err=1 after 1 edge.
  - p=4, q=0, gcd=4 -> lcm=0, err=0.
- Error and maximum:
  - p=10, q=4, gcd=3 -> err=1, lcm=0 after 9 edges (divide remainder 1).
  - p=255, q=254, gcd=1 -> lcm=64770, no overflow.
- Backpressure: p=120, q=10, gcd=10, out_ready=0 for 5 cycles after out_valid -> lcm=120 held stable, in_ready stays 0; out_ready=1 -> handshake, IDLE next cycle, in_ready=1.
- Reset mid-op: assert rst low during DIV (edge 4) -> out_valid=0 and in_ready=1 immediately (asynchronous); next triple p=25, q=100, gcd=25 -> lcm=100.
- With LCM_CHECK_Q_EN: p=12, q=10, gcd=4 -> err=1 after 17 edges; p=64, q=136, gcd=8 -> lcm=1088 after 25 edges.

Source files
------------

// File: rtl/lcm_from_gcd.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : lcm_from_gcd
// Purpose  : Least common multiple from an operand pair and its GCD.
//            LCM = (P / R) * Q, computed with a restoring shift-subtract
//            divider (one quotient bit per clock, MSB first) followed by a
//            shift-add multiplier (one multiplier bit per clock, LSB first).
//            Sits downstream of the Stein GCD stage with valid/ready on
//            both sides.
// Ports    : clk        - rising-edge clock
//            rst        - asynchronous reset, active LOW
//            in_valid   - operand triple {p, q, gcd} valid
//            in_ready   - block is idle and can take a triple
//            p, q       - operands as fed to the GCD stage (W bits)
//            gcd        - GCD(p, q) from the GCD stage (W bits)
//            out_valid  - lcm/err valid, held until out_ready
//            out_ready  - sink accepts the result
//            lcm        - least common multiple (2*W bits)
//            err        - inconsistent triple (gcd==0 with nonzero operands,
//                         or gcd does not divide p)
// Options  : define LCM_CHECK_Q_EN to add a second division pass (QCHK) that
//            also requires gcd to divide q; normal-path latency grows from
//            2W+1 to 3W+1 edges.
// Revision : 1.0 - initial release
// ============================================================================
module lcm_from_gcd #(
   parameter int W = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [W-1:0]   p,
   input  logic [W-1:0]   q,
   input  logic [W-1:0]   gcd,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*W-1:0] lcm,
   output logic           err
);

   localparam int            CW       = (W > 1) ? $clog2(W) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_DIV  = 3'd1,
`ifdef LCM_CHECK_Q_EN
      S_QCHK = 3'd2,
`endif
      S_MUL  = 3'd3,
      S_DONE = 3'd4
   } state_t;

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   state_t           state_q,     state_d;
   logic [CW-1:0]    cnt_q,       cnt_d;        // iteration counter
   logic [W-1:0]     q_q,         q_d;          // latched operand Q
   logic [W-1:0]     g_q,         g_d;          // latched divisor (gcd)
   logic [W-1:0]     dvd_q,       dvd_d;        // dividend in, quotient out
   logic [W-1:0]     rem_q,       rem_d;        // partial remainder
   logic [W-1:0]     mpl_q,       mpl_d;        // multiplier (quotient)
   logic [2*W-1:0]   mcd_q,       mcd_d;        // multiplicand (Q), shifts up
   logic [2*W-1:0]   acc_q,       acc_d;        // product accumulator
   logic             in_ready_q,  in_ready_d;
   logic             out_valid_q, out_valid_d;
   logic [2*W-1:0]   lcm_q,       lcm_d;
   logic             err_q,       err_d;

   // ---------------------------------------------------------------------
   // One restoring-division step and one shift-add step
   // ---------------------------------------------------------------------
   logic [W:0]       rem_sh;     // remainder with next dividend bit shifted in
   logic             sub_ok;     // divisor fits: quotient bit is 1
   logic [W-1:0]     rem_nx;
   logic [W-1:0]     dvd_nx;
   logic [2*W-1:0]   acc_nx;
   logic             cnt_last;

   always_comb begin
      rem_sh   = {rem_q, dvd_q[W-1]};
      sub_ok   = (rem_sh >= {1'b0, g_q});
      // After a successful subtract the remainder is below the divisor,
      // so it always fits back into W bits.
      rem_nx   = W'(sub_ok ? (rem_sh - {1'b0, g_q}) : rem_sh);
      // Dividend bits leave at the top while quotient bits enter at the
      // bottom; after W steps dvd holds the quotient.
      dvd_nx   = {dvd_q[W-2:0], sub_ok};
      acc_nx   = mpl_q[0] ? (acc_q + mcd_q) : acc_q;
      cnt_last = (cnt_q == CNT_LAST);
   end

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      q_d     = q_q;
      g_d     = g_q;
      dvd_d   = dvd_q;
      rem_d   = rem_q;
      mpl_d   = mpl_q;
      mcd_d   = mcd_q;
      acc_d   = acc_q;
      lcm_d   = lcm_q;
      err_d   = err_q;

      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               q_d   = q;
               g_d   = gcd;
               dvd_d = p;
               rem_d = '0;
               cnt_d = '0;
               acc_d = '0;
               if ((p == '0) || (q == '0)) begin
                  // LCM with a zero operand is zero; gcd is irrelevant.
                  state_d = S_DONE;
                  lcm_d   = '0;
                  err_d   = 1'b0;
               end else if (gcd == '0) begin
                  state_d = S_DONE;
                  lcm_d   = '0;
                  err_d   = 1'b1;
               end else begin
                  state_d = S_DIV;
               end
            end
         end

         S_DIV: begin
            rem_d = rem_nx;
            dvd_d = dvd_nx;
            cnt_d = cnt_q + CW'(1);
            if (cnt_last) begin
               cnt_d = '0;
               if (rem_nx != '0) begin
                  state_d = S_DONE;
                  lcm_d   = '0;
                  err_d   = 1'b1;
               end else begin
                  // Park the quotient in the multiplier before the divider
                  // registers are (optionally) reused for the Q check.
                  mpl_d = dvd_nx;
                  mcd_d = {{W{1'b0}}, q_q};
                  acc_d = '0;
`ifdef LCM_CHECK_Q_EN
                  state_d = S_QCHK;
                  dvd_d   = q_q;
                  rem_d   = '0;
`else
                  state_d = S_MUL;
`endif
               end
            end
         end

`ifdef LCM_CHECK_Q_EN
         S_QCHK: begin
            // Only the remainder of q / gcd matters here.
            rem_d = rem_nx;
            dvd_d = dvd_nx;
            cnt_d = cnt_q + CW'(1);
            if (cnt_last) begin
               cnt_d = '0;
               if (rem_nx != '0) begin
                  state_d = S_DONE;
                  lcm_d   = '0;
                  err_d   = 1'b1;
               end else begin
                  state_d = S_MUL;
               end
            end
         end
`endif

         S_MUL: begin
            acc_d = acc_nx;
            mcd_d = mcd_q << 1;
            mpl_d = mpl_q >> 1;
            cnt_d = cnt_q + CW'(1);
            if (cnt_last) begin
               // (2^W-1)^2 < 2^(2W): the accumulator cannot overflow.
               cnt_d   = '0;
               state_d = S_DONE;
               lcm_d   = acc_nx;
               err_d   = 1'b0;
            end
         end

         S_DONE: begin
            // lcm/err are untouched here, so they stay stable under
            // backpressure and keep their value through IDLE afterwards.
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Handshake flags are registered copies of the next state.
      in_ready_d  = (state_d == S_IDLE);
      out_valid_d = (state_d == S_DONE);
   end

   // ---------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         q_q         <= '0;
         g_q         <= '0;
         dvd_q       <= '0;
         rem_q       <= '0;
         mpl_q       <= '0;
         mcd_q       <= '0;
         acc_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         lcm_q       <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         q_q         <= q_d;
         g_q         <= g_d;
         dvd_q       <= dvd_d;
         rem_q       <= rem_d;
         mpl_q       <= mpl_d;
         mcd_q       <= mcd_d;
         acc_q       <= acc_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         lcm_q       <= lcm_d;
         err_q       <= err_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign lcm       = lcm_q;
   assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_lcm_from_gcd.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_lcm_from_gcd
// Purpose  : Self-checking bench for lcm_from_gcd (W=8). Expected results are
//            pushed to a scoreboard queue when a triple is driven and popped
//            when the result appears. Honours LCM_CHECK_Q_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lcm_from_gcd;

   localparam int W = 8;
`ifdef LCM_CHECK_Q_EN
   localparam int LAT_FULL = 3*W + 1;
`else
   localparam int LAT_FULL = 2*W + 1;
`endif
   localparam int LAT_DIV_ERR = W + 1;
   localparam int TIMEOUT     = 200;
   localparam int PERIOD      = 10;

   typedef struct {
      logic [W-1:0]   a;
      logic [W-1:0]   b;
      logic [W-1:0]   g;
      logic [2*W-1:0] l;
      logic           e;
      int             lat;
      string          name;
   } row_t;

   typedef struct {
      logic [2*W-1:0] lcm;
      logic           err;
      int             lat;
   } exp_t;

   logic           clk = 1'b0;
   logic           rst;
   logic           in_valid;
   logic           in_ready;
   logic [W-1:0]   p;
   logic [W-1:0]   q;
   logic [W-1:0]   gcd;
   logic           out_valid;
   logic           out_ready;
   logic [2*W-1:0] lcm;
   logic           err;

   int   n_pass  = 0;
   int   n_total = 0;
   exp_t sb[$];

   always #(PERIOD/2) clk = ~clk;

   lcm_from_gcd #(.W(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .p         (p),
      .q         (q),
      .gcd       (gcd),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .lcm       (lcm),
      .err       (err)
   );

   function automatic row_t mk_row(int a, int b, int g, int l, bit e, int lat, string n);
      row_t rw;
      rw.a = W'(a);  rw.b = W'(b);  rw.g = W'(g);
      rw.l = (2*W)'(l);  rw.e = e;  rw.lat = lat;  rw.name = n;
      return rw;
   endfunction

   function automatic int gcd_ref(int a, int b);
      int t;
      while (b != 0) begin
         t = a % b;
         a = b;
         b = t;
      end
      return a;
   endfunction

   // Drive one triple; returns #1 after the accept edge. Operand pins are
   // scrambled afterwards so a design that re-samples them is exposed.
   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] g, output time t_acc);
      int guard = 0;
      @(negedge clk);
      while (!in_ready && guard < TIMEOUT) begin
         @(negedge clk);
         guard++;
      end
      p = a;  q = b;  gcd = g;  in_valid = 1'b1;
      @(posedge clk);
      t_acc = $time;
      #1;
      in_valid = 1'b0;
      p   = W'($urandom);
      q   = W'($urandom);
      gcd = W'($urandom);
   endtask

   // Wait for out_valid; lat counts edges with the accept edge as edge 1.
   task automatic collect(output int lat, output logic [2*W-1:0] r, output logic e);
      lat = 1;
      while (!out_valid && lat < TIMEOUT) begin
         @(posedge clk);
         #1;
         lat++;
      end
      r = lcm;
      e = err;
   endtask

   task automatic run_one(input row_t rw, output int lat, output logic [2*W-1:0] r,
                          output logic e, output time t_acc);
      exp_t x;
      x.lcm = rw.l;  x.err = rw.e;  x.lat = rw.lat;
      sb.push_back(x);
      send(rw.a, rw.b, rw.g, t_acc);
      collect(lat, r, e);
   endtask

   task automatic wait_idle();
      int guard = 0;
      while (!in_ready && guard < TIMEOUT) begin
         @(posedge clk);
         #1;
         guard++;
      end
   endtask

   // ---------------------------------------------------------------------
   task automatic test_reset();
      rst = 1'b0;  in_valid = 1'b0;  out_ready = 1'b1;
      p = '0;  q = '0;  gcd = '0;
      repeat (2) @(posedge clk);
      #1;
      n_total++; if (in_ready !== 1'b1) $display("FAIL reset in_ready: got %b want 1", in_ready); else n_pass++;
      n_total++; if (out_valid !== 1'b0) $display("FAIL reset out_valid: got %b want 0", out_valid); else n_pass++;
      n_total++; if (lcm !== '0) $display("FAIL reset lcm: got %0d want 0", lcm); else n_pass++;
      n_total++; if (err !== 1'b0) $display("FAIL reset err: got %b want 0", err); else n_pass++;
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_basic();
      row_t rows[3];
      exp_t x;  int lat;  logic [2*W-1:0] r;  logic e;  time t;
      rows[0] = mk_row(8,   4,  4,  8,   1'b0, LAT_FULL, "basic_8_4_4");
      rows[1] = mk_row(100, 25, 25, 100, 1'b0, LAT_FULL, "basic_100_25_25");
      rows[2] = mk_row(67,  9,  1,  603, 1'b0, LAT_FULL, "basic_67_9_1");
      foreach (rows[i]) begin
         run_one(rows[i], lat, r, e, t);
         x = sb.pop_front();
         n_total++; if (r !== x.lcm) $display("FAIL %s lcm: got %0d want %0d", rows[i].name, r, x.lcm); else n_pass++;
         n_total++; if (e !== x.err) $display("FAIL %s err: got %b want %b", rows[i].name, e, x.err); else n_pass++;
         n_total++; if (lat !== x.lat) $display("FAIL %s latency: got %0d want %0d", rows[i].name, lat, x.lat); else n_pass++;
      end
   endtask

   task automatic test_fast_path();
      row_t rows[3];
      exp_t x;  int lat;  logic [2*W-1:0] r;  logic e;  time t;
      rows[0] = mk_row(0, 3, 3, 0, 1'b0, 1, "fast_p0");
      rows[1] = mk_row(3, 3, 0, 0, 1'b1, 1, "fast_gcd0");
      rows[2] = mk_row(4, 0, 4, 0, 1'b0, 1, "fast_q0");
      foreach (rows[i]) begin
         run_one(rows[i], lat, r, e, t);
         x = sb.pop_front();
         n_total++; if (r !== x.lcm) $display("FAIL %s lcm: got %0d want %0d", rows[i].name, r, x.lcm); else n_pass++;
         n_total++; if (e !== x.err) $display("FAIL %s err: got %b want %b", rows[i].name, e, x.err); else n_pass++;
         n_total++; if (lat !== x.lat) $display("FAIL %s latency: got %0d want %0d", rows[i].name, lat, x.lat); else n_pass++;
      end
   endtask

   task automatic test_error_max();
      row_t rows[2];
      exp_t x;  int lat;  logic [2*W-1:0] r;  logic e;  time t;
      rows[0] = mk_row(10,  4,   3, 0,     1'b1, LAT_DIV_ERR, "err_10_4_3");
      rows[1] = mk_row(255, 254, 1, 64770, 1'b0, LAT_FULL,    "max_255_254_1");
      foreach (rows[i]) begin
         run_one(rows[i], lat, r, e, t);
         x = sb.pop_front();
         n_total++; if (r !== x.lcm) $display("FAIL %s lcm: got %0d want %0d", rows[i].name, r, x.lcm); else n_pass++;
         n_total++; if (e !== x.err) $display("FAIL %s err: got %b want %b", rows[i].name, e, x.err); else n_pass++;
         n_total++; if (lat !== x.lat) $display("FAIL %s latency: got %0d want %0d", rows[i].name, lat, x.lat); else n_pass++;
      end
   endtask

   // With the check enabled gcd must divide q too; without it the block
   // trusts q and returns (p/gcd)*q.
   task automatic test_check_q();
      row_t rows[2];
      exp_t x;  int lat;  logic [2*W-1:0] r;  logic e;  time t;
`ifdef LCM_CHECK_Q_EN
      rows[0] = mk_row(12, 10,  4, 0,    1'b1, 2*W + 1,  "qchk_12_10_4");
`else
      rows[0] = mk_row(12, 10,  4, 30,   1'b0, LAT_FULL, "qchk_12_10_4");
`endif
      rows[1] = mk_row(64, 136, 8, 1088, 1'b0, LAT_FULL, "qchk_64_136_8");
      foreach (rows[i]) begin
         run_one(rows[i], lat, r, e, t);
         x = sb.pop_front();
         n_total++; if (r !== x.lcm) $display("FAIL %s lcm: got %0d want %0d", rows[i].name, r, x.lcm); else n_pass++;
         n_total++; if (e !== x.err) $display("FAIL %s err: got %b want %b", rows[i].name, e, x.err); else n_pass++;
         n_total++; if (lat !== x.lat) $display("FAIL %s latency: got %0d want %0d", rows[i].name, lat, x.lat); else n_pass++;
      end
   endtask

   task automatic test_backpressure();
      exp_t x;  int lat;  logic [2*W-1:0] r;  logic e;  time t;
      wait_idle();
      @(negedge clk);
      out_ready = 1'b0;
      run_one(mk_row(120, 10, 10, 120, 1'b0, LAT_FULL, "bp"), lat, r, e, t);
      x = sb.pop_front();
      n_total++; if (r !== x.lcm) $display("FAIL bp lcm: got %0d want %0d", r, x.lcm); else n_pass++;
      n_total++; if (lat !== x.lat) $display("FAIL bp latency: got %0d want %0d", lat, x.lat); else n_pass++;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         n_total++;
         if ({out_valid, in_ready, err, lcm} !== {1'b1, 1'b0, 1'b0, x.lcm})
            $display("FAIL bp hold cycle %0d: got valid=%b ready=%b err=%b lcm=%0d want valid=1 ready=0 err=0 lcm=%0d",
                     i, out_valid, in_ready, err, lcm, x.lcm);
         else n_pass++;
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      n_total++; if ({out_valid, in_ready} !== 2'b01) $display("FAIL bp release: got valid=%b ready=%b want valid=0 ready=1", out_valid, in_ready); else n_pass++;
      n_total++; if (lcm !== x.lcm) $display("FAIL bp idle hold lcm: got %0d want %0d", lcm, x.lcm); else n_pass++;
   endtask

   task automatic test_reset_mid_op();
      exp_t x;  int lat;  logic [2*W-1:0] r;  logic e;  time t;  int spurious;
      out_ready = 1'b1;
      send(8'd200, 8'd7, 8'd25, t);      // 200/25 -> normal path, aborted below
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      n_total++; if (out_valid !== 1'b0) $display("FAIL midrst out_valid: got %b want 0", out_valid); else n_pass++;
      n_total++; if (in_ready !== 1'b1) $display("FAIL midrst in_ready: got %b want 1", in_ready); else n_pass++;
      n_total++; if (lcm !== '0) $display("FAIL midrst lcm cleared: got %0d want 0", lcm); else n_pass++;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      spurious = 0;
      for (int i = 0; i < LAT_FULL + 4; i++) begin
         @(posedge clk);
         #1;
         if (out_valid) spurious++;
      end
      n_total++; if (spurious !== 0) $display("FAIL midrst no result: got %0d valid cycles want 0", spurious); else n_pass++;
      run_one(mk_row(25, 100, 25, 100, 1'b0, LAT_FULL, "after_rst"), lat, r, e, t);
      x = sb.pop_front();
      n_total++; if (r !== x.lcm) $display("FAIL after_rst lcm: got %0d want %0d", r, x.lcm); else n_pass++;
      n_total++; if (e !== x.err) $display("FAIL after_rst err: got %b want %b", e, x.err); else n_pass++;
      n_total++; if (lat !== x.lat) $display("FAIL after_rst latency: got %0d want %0d", lat, x.lat); else n_pass++;
   endtask

   // Consistent random triples with out_ready held high: each result must
   // match, and accepts must be exactly LAT_FULL+1 cycles apart.
   task automatic test_back_to_back();
      exp_t x;  int lat;  logic [2*W-1:0] r;  logic e;
      time t_prev, t_now;
      int a, b, g;
      out_ready = 1'b1;
      wait_idle();
      for (int i = 0; i < 4; i++) begin
         a = $urandom_range(1, 255);
         b = $urandom_range(1, 255);
         g = gcd_ref(a, b);
         run_one(mk_row(a, b, g, (a / g) * b, 1'b0, LAT_FULL, "b2b"), lat, r, e, t_now);
         x = sb.pop_front();
         n_total++; if ({e, r} !== {x.err, x.lcm}) $display("FAIL b2b %0d (%0d,%0d,%0d): got err=%b lcm=%0d want err=%b lcm=%0d", i, a, b, g, e, r, x.err, x.lcm); else n_pass++;
         if (i > 0) begin
            n_total++;
            if ((t_now - t_prev) !== time'((LAT_FULL + 1) * PERIOD))
               $display("FAIL b2b %0d accept spacing: got %0t want %0d", i, t_now - t_prev, (LAT_FULL + 1) * PERIOD);
            else n_pass++;
         end
         t_prev = t_now;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_fast_path();
      test_error_max();
      test_check_q();
      test_backpressure();
      test_reset_mid_op();
      test_back_to_back();
      n_total++; if (sb.size() !== 0) $display("FAIL scoreboard drain: got %0d entries want 0", sb.size()); else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
